vga_write_arbiter: RTL and testbench
====================================

VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3, meaning pixel colour width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning video-RAM address width.
REQ-003 SHALL have parameter MEM_SIZE, default 192, meaning the number of valid video-RAM locations (16x12).
REQ-004 SHALL have port Clock, input, 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port iCpuWrite, input, 1, CPU pixel-write request (VGA instruction).
REQ-007 SHALL have port iCpuAddr, input, ADDR_WIDTH, CPU write address.
REQ-008 SHALL have port iCpuData, input, DATA_WIDTH, CPU write colour.
REQ-009 SHALL have port oCpuStall, output, 1, CPU must hold its request and instruction pointer while high.
REQ-010 SHALL have port iFillStart, input, 1, single-cycle fill start pulse.
REQ-011 SHALL have port iFillBase, input, ADDR_WIDTH, first fill address.
REQ-012 SHALL have port iFillCount, input, 8, number of pixels to fill.
REQ-013 SHALL have port iFillColor, input, DATA_WIDTH, fill colour.
REQ-014 SHALL have port oFillBusy, output, 1, fill in progress.
REQ-015 SHALL have port oFillDone, output, 1, one-cycle completion pulse.
REQ-016 SHALL have ports oWriteEnable (output, 1), oWriteAddress (output, ADDR_WIDTH) and oWriteData (output, DATA_WIDTH), the video-RAM write port.

Function
REQ-017 SHALL register oWriteEnable, oWriteAddress and oWriteData: a grant in cycle N produces the write in cycle N+1.
REQ-018 SHALL use fill FSM states IDLE, FILL and DONE; IDLE->FILL on iFillStart with count>0; IDLE->DONE on iFillStart with count=0; FILL->DONE after the last granted write; DONE->IDLE after one cycle.
REQ-019 SHALL latch base, colour and min(iFillCount, MEM_SIZE) on an accepted iFillStart.
REQ-020 SHALL ignore iFillStart while not in IDLE.
REQ-021 SHALL step the fill address as addr+1, wrapping MEM_SIZE-1 -> 0.
REQ-022 SHALL assert oFillBusy in FILL and DONE, and oFillDone only in DONE.
REQ-023 SHALL arbitrate round-robin when CPU and fill both request: the requester not granted last wins; a lone requester always wins.
REQ-024 SHALL assert oCpuStall combinationally in any cycle where iCpuWrite=1 and the CPU is not granted.
REQ-025 SHALL not advance the fill address or count in any cycle the fill loses arbitration.
REQ-026 SHALL grant the CPU a CPU write coinciding with an accepted iFillStart; the fill begins requesting the next cycle.
REQ-027 SHALL grant a CPU write with iCpuAddr >= MEM_SIZE but drop it: oWriteEnable stays 0 and there is no stall beyond arbitration.
REQ-028 SHALL only ever generate fill addresses below MEM_SIZE; if iFillBase >= MEM_SIZE, the first fill address is 0.

Reset
REQ-029 SHALL, on Reset low, asynchronously force: FSM to IDLE; oWriteEnable, oFillBusy, oFillDone and oCpuStall to 0; oWriteAddress and oWriteData to 0; last-grant to CPU.
REQ-030 SHALL abandon a fill if reset occurs mid-fill, with no further writes and no oFillDone pulse.

Configuration
REQ-031 SHALL, when macro VGA_FILL_ENGINE_EN is defined, include the fill FSM and arbitration.
REQ-032 SHALL, when VGA_FILL_ENGINE_EN is undefined, keep all ports, ignore the fill inputs, tie oFillBusy, oFillDone and oCpuStall to 0, and pass CPU writes with one-cycle latency.

Structure
REQ-033 SHALL take the FSM state encoding, grant-owner constants and default parameter values from shared package vga_arb_pkg.
REQ-034 SHALL implement the FSM, address and count logic in sub-module vga_fill_sequencer, with the arbiter and output registers in the top.

Verification
REQ-035 SHALL verify: iCpuWrite=1, addr=0x25, data=3'b101, no fill -> next cycle oWriteEnable=1, addr 0x25, data 101, oCpuStall=0.
REQ-036 SHALL verify: fill base=0, count=4, colour=010 -> writes to 0,1,2,3 on consecutive cycles, then oFillDone pulse, oFillBusy low 2 cycles after the last write.
REQ-037 SHALL verify: fill base=190, count=5 -> write addresses 190, 191, 0, 1, 2.
REQ-038 SHALL verify: a CPU write held during a fill of count=3 -> grants alternate fill/CPU, oCpuStall high exactly on the fill-granted cycles, with 4 total writes.
REQ-039 SHALL verify: count=0 -> no writes, oFillDone 1 cycle after start; count=255 -> exactly 192 writes.
REQ-040 SHALL verify: Reset low after the 2nd fill write -> outputs 0 immediately, no oFillDone, and a new fill is accepted after release.

Source files
------------

// File: rtl/vga_arb_pkg.sv
// Shared definitions for the VGA write arbiter: default parameters, fill FSM
// state encoding and grant-owner constants.
package vga_arb_pkg;

    localparam int DATA_WIDTH_DEF = 3;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int MEM_SIZE_DEF   = 192;
    localparam int FILL_COUNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    typedef enum logic {
        GRANT_CPU  = 1'b0,
        GRANT_FILL = 1'b1
    } grant_t;

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Bundle of the CPU request, fill command and video-RAM write signals.
// slave is the arbiter's view; master is the view of whatever drives it.
interface vga_write_arbiter_if
    import vga_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);

    logic                    iCpuWrite;
    logic [ADDR_WIDTH-1:0]   iCpuAddr;
    logic [DATA_WIDTH-1:0]   iCpuData;
    logic                    oCpuStall;
    logic                    iFillStart;
    logic [ADDR_WIDTH-1:0]   iFillBase;
    logic [FILL_COUNT_W-1:0] iFillCount;
    logic [DATA_WIDTH-1:0]   iFillColor;
    logic                    oFillBusy;
    logic                    oFillDone;
    logic                    oWriteEnable;
    logic [ADDR_WIDTH-1:0]   oWriteAddress;
    logic [DATA_WIDTH-1:0]   oWriteData;

    modport slave (
        input  iCpuWrite, iCpuAddr, iCpuData,
        input  iFillStart, iFillBase, iFillCount, iFillColor,
        output oCpuStall, oFillBusy, oFillDone,
        output oWriteEnable, oWriteAddress, oWriteData
    );

    modport master (
        output iCpuWrite, iCpuAddr, iCpuData,
        output iFillStart, iFillBase, iFillCount, iFillColor,
        input  oCpuStall, oFillBusy, oFillDone,
        input  oWriteEnable, oWriteAddress, oWriteData
    );

endinterface

// File: rtl/vga_fill_sequencer.sv
// Fill engine: IDLE/FILL/DONE controller plus the fill address, remaining
// count and colour registers. Advances only on cycles its request is granted.
module vga_fill_sequencer
    import vga_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MEM_SIZE   = MEM_SIZE_DEF
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    fillStart,
    input  logic [ADDR_WIDTH-1:0]   fillBase,
    input  logic [FILL_COUNT_W-1:0] fillCount,
    input  logic [DATA_WIDTH-1:0]   fillColor,
    input  logic                    fillGrant,
    output logic                    fillReq,
    output logic [ADDR_WIDTH-1:0]   fillAddr,
    output logic [DATA_WIDTH-1:0]   fillData,
    output logic                    fillBusy,
    output logic                    fillDone
);

    localparam logic [ADDR_WIDTH:0]   MemSizeA = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] MemLast  = ADDR_WIDTH'(MEM_SIZE - 1);
    localparam logic [FILL_COUNT_W:0] MemSizeC = (FILL_COUNT_W + 1)'(MEM_SIZE);

    function automatic logic [FILL_COUNT_W-1:0] clampCount(input logic [FILL_COUNT_W-1:0] cnt);
        if ({1'b0, cnt} > MemSizeC) return MemSizeC[FILL_COUNT_W-1:0];
        return cnt;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] firstAddr(input logic [ADDR_WIDTH-1:0] base);
        if ({1'b0, base} >= MemSizeA) return '0;
        return base;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] nextAddr(input logic [ADDR_WIDTH-1:0] addr);
        if (addr == MemLast) return '0;
        return addr + ADDR_WIDTH'(1);
    endfunction

    fill_state_t             state, nextState;
    logic                    load, advance;
    logic [FILL_COUNT_W-1:0] remaining;
    logic [FILL_COUNT_W-1:0] startCount;

    assign startCount = clampCount(fillCount);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        load      = 1'b0;
        advance   = 1'b0;
        fillReq   = 1'b0;
        fillBusy  = 1'b0;
        fillDone  = 1'b0;
        case (state)
            IDLE: begin
                if (fillStart) begin
                    load      = 1'b1;
                    nextState = (startCount == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                fillReq  = 1'b1;
                fillBusy = 1'b1;
                if (fillGrant) begin
                    advance = 1'b1;
                    if (remaining == FILL_COUNT_W'(1)) nextState = DONE;
                end
            end
            DONE: begin
                fillBusy  = 1'b1;
                fillDone  = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Operand registers are reloaded on every accepted start, so they need no reset.
    always_ff @(posedge Clock) begin
        if (load) begin
            fillAddr  <= firstAddr(fillBase);
            remaining <= startCount;
            fillData  <= fillColor;
        end else if (advance) begin
            fillAddr  <= nextAddr(fillAddr);
            remaining <= remaining - FILL_COUNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Video-RAM write arbiter between CPU pixel writes and the fill engine.
// The fill engine and round-robin arbitration exist only with VGA_FILL_ENGINE_EN.
module vga_write_arbiter
    import vga_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int MEM_SIZE   = MEM_SIZE_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    vga_write_arbiter_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0] MemSizeA = (ADDR_WIDTH + 1)'(MEM_SIZE);

    logic                  cpuInRange;
    logic                  writeEnable_p1;
    logic [ADDR_WIDTH-1:0] writeAddress_p1;
    logic [DATA_WIDTH-1:0] writeData_p1;

    assign cpuInRange = ({1'b0, bus.iCpuAddr} < MemSizeA);

`ifdef VGA_FILL_ENGINE_EN
    logic                  fillReq, fillGrant, cpuGrant;
    logic                  fillBusy, fillDone;
    logic [ADDR_WIDTH-1:0] fillAddr;
    logic [DATA_WIDTH-1:0] fillData;
    grant_t                lastGrant;

    vga_fill_sequencer #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) uSequencer (
        .Clock     (Clock),
        .Reset     (Reset),
        .fillStart (bus.iFillStart),
        .fillBase  (bus.iFillBase),
        .fillCount (bus.iFillCount),
        .fillColor (bus.iFillColor),
        .fillGrant (fillGrant),
        .fillReq   (fillReq),
        .fillAddr  (fillAddr),
        .fillData  (fillData),
        .fillBusy  (fillBusy),
        .fillDone  (fillDone)
    );

    // On contention the side that did not win last time gets the slot.
    always_comb begin
        cpuGrant  = bus.iCpuWrite;
        fillGrant = fillReq;
        if (bus.iCpuWrite && fillReq) begin
            cpuGrant  = (lastGrant == GRANT_FILL);
            fillGrant = (lastGrant == GRANT_CPU);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)         lastGrant <= GRANT_CPU;
        else if (fillGrant) lastGrant <= GRANT_FILL;
        else if (cpuGrant)  lastGrant <= GRANT_CPU;
    end

    // Grant stage -> registered video-RAM write port.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            writeEnable_p1  <= 1'b0;
            writeAddress_p1 <= '0;
            writeData_p1    <= '0;
        end else if (fillGrant) begin
            writeEnable_p1  <= 1'b1;
            writeAddress_p1 <= fillAddr;
            writeData_p1    <= fillData;
        end else begin
            writeEnable_p1  <= cpuGrant && cpuInRange;
            writeAddress_p1 <= bus.iCpuAddr;
            writeData_p1    <= bus.iCpuData;
        end
    end

    assign bus.oCpuStall = Reset & bus.iCpuWrite & ~cpuGrant;
    assign bus.oFillBusy = fillBusy;
    assign bus.oFillDone = fillDone;
`else
    logic unusedFill;
    assign unusedFill = ^{bus.iFillStart, bus.iFillBase, bus.iFillCount, bus.iFillColor};

    // CPU request -> registered video-RAM write port.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            writeEnable_p1  <= 1'b0;
            writeAddress_p1 <= '0;
            writeData_p1    <= '0;
        end else begin
            writeEnable_p1  <= bus.iCpuWrite && cpuInRange;
            writeAddress_p1 <= bus.iCpuAddr;
            writeData_p1    <= bus.iCpuData;
        end
    end

    assign bus.oCpuStall = 1'b0;
    assign bus.oFillBusy = 1'b0;
    assign bus.oFillDone = 1'b0;
`endif

    assign bus.oWriteEnable  = writeEnable_p1;
    assign bus.oWriteAddress = writeAddress_p1;
    assign bus.oWriteData    = writeData_p1;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Scoreboard bench for vga_write_arbiter: a transaction-level model predicts
// every video-RAM write, stall, busy and done; a monitor checks the write port.
module tb_vga_write_arbiter;

    localparam int DW  = 3;
    localparam int AW  = 8;
    localparam int MEM = 192;
`ifdef VGA_FILL_ENGINE_EN
    localparam bit FillEn = 1'b1;
`else
    localparam bit FillEn = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    vga_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    vga_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MEM)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct { int addr; int data; } wr_t;
    wr_t expQ[$];

    int nChecks = 0;
    int nFail   = 0;
    int wrCount = 0;

    // Model: pending fill pixels, next fill address/colour, done cycle, last winner.
    int mFillRem = 0, mFillAddr = 0, mFillColor = 0, mFillPushed = 0;
    bit mDoneNow = 1'b0, mLastCpu = 1'b1;
    bit cpuPend = 1'b0, fsReq = 1'b0;
    int cpuAddr = 0, cpuData = 0, fsBase = 0, fsCount = 0, fsColor = 0;

    function automatic void check(string name, int act, int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge Clock) begin
        if (Reset) begin
            if (expQ.size() == 0) begin
                check("write-enable-idle", int'(bus.oWriteEnable), 0);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                check("write-enable", int'(bus.oWriteEnable), 1);
                check("write-addr", int'(bus.oWriteAddress), e.addr);
                check("write-data", int'(bus.oWriteData), e.data);
            end
            if (bus.oWriteEnable) wrCount++;
        end
    end

    // One clock cycle: entered and left just after a falling edge.
    task automatic step();
        bit fillWants, cpuWins, fillWins, busyNow, doneNext;
        bus.iCpuWrite  = cpuPend;
        bus.iCpuAddr   = AW'(cpuAddr);
        bus.iCpuData   = DW'(cpuData);
        bus.iFillStart = fsReq;
        bus.iFillBase  = AW'(fsBase);
        bus.iFillCount = 8'(fsCount);
        bus.iFillColor = DW'(fsColor);
        #1;
        fillWants = (mFillRem > 0);
        cpuWins   = cpuPend && (!fillWants || !mLastCpu);
        fillWins  = fillWants && !cpuWins;
        busyNow   = fillWants || mDoneNow;
        check("cpu-stall", int'(bus.oCpuStall), int'(cpuPend && !cpuWins));
        check("fill-busy", int'(bus.oFillBusy), int'(busyNow));
        check("fill-done", int'(bus.oFillDone), int'(mDoneNow));
        @(posedge Clock);
        doneNext = 1'b0;
        if (cpuWins) begin
            mLastCpu = 1'b1;
            if (cpuAddr < MEM) expQ.push_back('{cpuAddr, cpuData});
            cpuPend = 1'b0;
        end
        if (fillWins) begin
            mLastCpu = 1'b0;
            expQ.push_back('{mFillAddr, mFillColor});
            mFillPushed++;
            mFillAddr = (mFillAddr + 1) % MEM;
            mFillRem--;
            if (mFillRem == 0) doneNext = 1'b1;
        end
        if (FillEn && fsReq && !busyNow) begin
            mFillRem   = (fsCount > MEM) ? MEM : fsCount;
            mFillAddr  = (fsBase >= MEM) ? 0 : fsBase;
            mFillColor = fsColor;
            if (mFillRem == 0) doneNext = 1'b1;
        end
        mDoneNow = doneNext;
        fsReq    = 1'b0;
        @(negedge Clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic startFill(input int base, input int count, input int color);
        fsReq = 1'b1; fsBase = base; fsCount = count; fsColor = color;
        step();
    endtask

    task automatic cpuWrite(input int addr, input int data);
        cpuPend = 1'b1; cpuAddr = addr; cpuData = data;
    endtask

    initial begin
        int w0, guard, r;
        bus.iCpuWrite = 1'b0; bus.iCpuAddr = '0; bus.iCpuData = '0;
        bus.iFillStart = 1'b0; bus.iFillBase = '0; bus.iFillCount = '0; bus.iFillColor = '0;
        #3;
        check("reset-we", int'(bus.oWriteEnable), 0);
        check("reset-addr", int'(bus.oWriteAddress), 0);
        check("reset-data", int'(bus.oWriteData), 0);
        check("reset-busy", int'(bus.oFillBusy), 0);
        check("reset-done", int'(bus.oFillDone), 0);
        check("reset-stall", int'(bus.oCpuStall), 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        // Single CPU write, in range and then out of range.
        cpuWrite(8'h25, 3'b101); step();
        run(2);
        cpuWrite(200, 3'b011); step();
        run(2);

        // Plain fills, address wrap, out-of-range base.
        startFill(0, 4, 3'b010); run(7);
        startFill(190, 5, 3'b110); run(8);
        startFill(200, 3, 3'b001); run(6);

        // CPU write alongside a fill start, then a held write during the fill.
        cpuWrite(8'h30, 1); startFill(100, 3, 3'b100);
        #1 w0 = wrCount;
        cpuWrite(8'h31, 6);
        run(4);
        #1 check("contended-write-count", wrCount - w0, FillEn ? 4 : 1);
        run(3);

        // Zero-length and over-length fills.
        startFill(5, 0, 3'b111); run(3);
        #1 w0 = wrCount;
        startFill(0, 255, 3'b011); run(200);
        #1 check("clamped-fill-count", wrCount - w0, FillEn ? 192 : 0);

        // Reset after the second write of a fill.
        mFillPushed = 0;
        startFill(10, 6, 3'b101);
        guard = 0;
        while (FillEn && mFillPushed < 2 && guard < 20) begin step(); guard++; end
        check("pre-reset-wait", int'(guard < 20), 1);
        #2 Reset = 1'b0;
        bus.iCpuWrite = 1'b0; bus.iFillStart = 1'b0;
        #1;
        check("async-reset-we", int'(bus.oWriteEnable), 0);
        check("async-reset-addr", int'(bus.oWriteAddress), 0);
        check("async-reset-data", int'(bus.oWriteData), 0);
        check("async-reset-busy", int'(bus.oFillBusy), 0);
        check("async-reset-done", int'(bus.oFillDone), 0);
        expQ.delete();
        mFillRem = 0; mDoneNow = 1'b0; mLastCpu = 1'b1; cpuPend = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        run(4);
        startFill(50, 3, 3'b010); run(6);

        // Randomised traffic; a stalled CPU keeps its request unchanged.
        for (int i = 0; i < 2500; i++) begin
            if (!cpuPend && $urandom_range(0, 99) < 40)
                cpuWrite(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
            if ($urandom_range(0, 99) < 4) begin
                fsReq = 1'b1;
                fsBase = int'($urandom_range(0, 255));
                fsColor = int'($urandom_range(0, 7));
                r = int'($urandom_range(0, 9));
                fsCount = (r == 0) ? 0 : (r == 1) ? 255 : int'($urandom_range(1, 20));
            end
            step();
        end
        run(400);
        check("queue-drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
